// File: rtl/result_collector_pkg.sv
// result_collector shared types and helpers.
// Also used by the scheduler for counter sizing.
package result_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } rc_state_e;

  // Width of one packed result row.
  function automatic int row_w(input int n, input int dw);
    return n * dw;
  endfunction

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/result_row_fifo.sv
// Aligned-row FIFO, show-ahead head on rdata.
// A push into a full FIFO lands only if a pop frees the slot.
module result_row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr, rd;

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW])
              && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;

  // Next pointers and storage; flush wins.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr) begin
        mem_d[wptr_q[AW-1:0]] = wdata;
        wptr_d = wptr_q + 1'b1;
      end
      if (rd) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Deskews systolic-array outputs into rows, buffers and streams them.
// Optional RESULT_COLLECTOR_ROW_TAG_EN adds out_row_idx.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           general_enable,
  input  logic                           start,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] psum_in,
  input  logic [MATRIX_SIZE-1:0]         psum_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           done,
  output logic                           overflow,
  output logic                           skew_err
`ifdef RESULT_COLLECTOR_ROW_TAG_EN
  ,
  output logic [$clog2(MATRIX_SIZE)-1:0] out_row_idx
`endif
);

  localparam int ROW_W = row_w(MATRIX_SIZE, DATA_SIZE);
  localparam int CW    = cnt_w(MATRIX_SIZE);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] N_C = CW'(MATRIX_SIZE);
`ifdef RESULT_COLLECTOR_ROW_TAG_EN
  localparam int IW = $clog2(MATRIX_SIZE);
  localparam int FW = ROW_W + IW;
`else
  localparam int FW = ROW_W;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == N_C) ? v : v + 1'b1;
  endfunction

  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] al_data;
  logic [MATRIX_SIZE-1:0]                al_vld;
  logic                                  row_vld, skew_now;

  rc_state_e     state_q, state_d;
  logic [CW-1:0] rows_in_q, rows_in_d;
  logic [CW-1:0] rows_out_q, rows_out_d;
  logic          ovf_q, ovf_d;
  logic          skew_q, skew_d;

  logic          push, pop, flush;
  logic          full, empty, empty_next;
  logic [LW-1:0] level;
  logic [FW-1:0] wdata, rdata;

  // Column j waits MATRIX_SIZE-1-j enabled cycles.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int D = MATRIX_SIZE - 1 - j;
    if (D == 0) begin : g_pass
      assign al_data[j] = psum_in[j*DATA_SIZE +: DATA_SIZE];
      assign al_vld[j]  = psum_valid[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] dat_q [D];
      logic [DATA_SIZE-1:0] dat_d [D];
      logic [D-1:0]         vld_q, vld_d;

      // Shift one stage per enabled cycle.
      always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (general_enable) begin
          dat_d[0] = psum_in[j*DATA_SIZE +: DATA_SIZE];
          vld_d[0] = psum_valid[j];
          for (int k = 1; k < D; k++) begin
            dat_d[k] = dat_q[k-1];
            vld_d[k] = vld_q[k-1];
          end
        end
      end

      // Delay-line registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dat_q <= '{default: '0};
          vld_q <= '0;
        end else begin
          dat_q <= dat_d;
          vld_q <= vld_d;
        end
      end

      assign al_data[j] = dat_q[D-1];
      assign al_vld[j]  = vld_q[D-1];
    end
  end

  assign row_vld  = al_vld[0];
  assign skew_now = |(al_vld ^ {MATRIX_SIZE{al_vld[0]}});

  assign out_valid  = !empty && general_enable;
  assign pop        = out_valid && out_ready;
  assign empty_next = empty || (level == LW'(1) && pop);
  assign out_data   = rdata[ROW_W-1:0];
  assign done       = state_q == DONE;
  assign overflow   = ovf_q;
  assign skew_err   = skew_q;

`ifdef RESULT_COLLECTOR_ROW_TAG_EN
  assign wdata       = {rows_in_q[IW-1:0], al_data};
  assign out_row_idx = rdata[ROW_W +: IW];
`else
  assign wdata = al_data;
`endif

  result_row_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // FSM next state, counters, sticky flags.
  always_comb begin
    state_d    = state_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;
    ovf_d      = ovf_q;
    skew_d     = skew_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (general_enable) begin
      if (skew_now) skew_d = 1'b1;
      if (pop) rows_out_d = sat_inc(rows_out_q);
      unique case (state_q)
        COLLECT: begin
          if (row_vld) begin
            push      = 1'b1;
            rows_in_d = sat_inc(rows_in_q);
            if (full && !pop) ovf_d = 1'b1;
            if (rows_in_d == N_C) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (row_vld) skew_d = 1'b1;
          if (rows_out_d == N_C || (ovf_q && empty_next))
            state_d = DONE;
        end
        default: ;
      endcase
    end
    if (start) begin
      state_d    = COLLECT;
      rows_in_d  = '0;
      rows_out_d = '0;
      ovf_d      = 1'b0;
      skew_d     = 1'b0;
      flush      = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      ovf_q      <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      ovf_q      <= ovf_d;
      skew_q     <= skew_d;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector against a queue-level model.
// Build with RESULT_COLLECTOR_ROW_TAG_EN to also check row tags.
module tb_result_collector;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int RW    = N * DW;
  localparam int HMAX  = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic          general_enable;
  logic          start;
  logic [RW-1:0] psum_in;
  logic [N-1:0]  psum_valid;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          overflow;
  logic          skew_err;
`ifdef RESULT_COLLECTOR_ROW_TAG_EN
  logic [$clog2(N)-1:0] out_row_idx;
`endif

  always #5 clk = ~clk;

  result_collector #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .general_enable (general_enable),
    .start          (start),
    .psum_in        (psum_in),
    .psum_valid     (psum_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .done           (done),
    .overflow       (overflow),
`ifdef RESULT_COLLECTOR_ROW_TAG_EN
    .out_row_idx    (out_row_idx),
`endif
    .skew_err       (skew_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Reference model: input history per enabled tick,
  // a row queue and the matrix bookkeeping.
  typedef struct {
    logic [RW-1:0] d;
    int            idx;
  } ent_t;

  logic [N-1:0]  hv [HMAX];
  logic [RW-1:0] hd [HMAX];
  int   tick = 0;
  int   base = 0;
  ent_t q[$];
  bit   started, m_done, m_ovf, m_skew;
  int   arrived, popped;

  function automatic logic in_v(input int t, input int j);
    if (t < base) return 1'b0;
    return hv[t][j];
  endfunction

  function automatic logic [DW-1:0] in_d(input int t, input int j);
    if (t < base) return '0;
    return hd[t][j*DW +: DW];
  endfunction

  task automatic model_reset();
    q.delete();
    started = 0; m_done = 0; m_ovf = 0; m_skew = 0;
    arrived = 0; popped = 0;
    base = tick;
  endtask

  task automatic model_edge(input bit en, input bit st,
                            input bit rdy);
    bit pop, a_v, sk, was_drain, ovf_prev, full;
    logic [RW-1:0] a_d;
    ent_t e;
    int t;
    a_v = 0; sk = 0; a_d = '0;
    pop = en && q.size() > 0 && rdy;
    if (en) begin
      t = tick;
      hv[t] = psum_valid;
      hd[t] = psum_in;
      tick++;
      // Row aligned now: column j entered N-1-j ticks ago.
      a_v = in_v(t - (N - 1), 0);
      for (int j = 0; j < N; j++) begin
        if (in_v(t - (N - 1 - j), j) != a_v) sk = 1;
        a_d[j*DW +: DW] = in_d(t - (N - 1 - j), j);
      end
    end
    if (st) begin
      q.delete();
      started = 1; m_done = 0; m_ovf = 0; m_skew = 0;
      arrived = 0; popped = 0;
      return;
    end
    if (!en) return;
    if (sk) m_skew = 1;
    was_drain = started && !m_done && arrived == N;
    ovf_prev = m_ovf;
    if (a_v && was_drain) m_skew = 1;
    full = q.size() == DEPTH;
    if (pop) begin
      void'(q.pop_front());
      if (popped < N) popped++;
    end
    if (a_v && started && !m_done && arrived < N) begin
      if (full && !pop) m_ovf = 1;
      else begin
        e.d = a_d;
        e.idx = arrived;
        q.push_back(e);
      end
      arrived++;
    end
    if (was_drain &&
        (popped == N || (ovf_prev && q.size() == 0)))
      m_done = 1;
  endtask

  task automatic compare();
    chk("out_valid", out_valid,
        (q.size() > 0) && general_enable);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
`ifdef RESULT_COLLECTOR_ROW_TAG_EN
      chk("row_idx", out_row_idx, q[0].idx);
`endif
    end
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    chk("skew_err", skew_err, m_skew);
  endtask

  // One clock: drive after posedge, check at negedge.
  task automatic cycle(input bit en, input bit st, input bit rdy,
                       input logic [N-1:0] v,
                       input logic [RW-1:0] d);
    general_enable = en;
    start = st;
    out_ready = rdy;
    psum_valid = v;
    psum_in = d;
    @(negedge clk);
    compare();
    model_edge(en, st, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    cycle(1, 1, 0, '0, '0);
  endtask

  // Stimulus plan per enabled tick: rows start at
  // increasing offsets, column j lagging by j.
  logic [N-1:0]  pv [64];
  logic [RW-1:0] pd [64];
  int plen;

  task automatic build(input int gmax, input int skew_row);
    int s;
    for (int i = 0; i < 64; i++) begin
      pv[i] = '0;
      pd[i] = '0;
    end
    s = 0;
    for (int r = 0; r < N; r++) begin
      if (r > 0) s += $urandom_range(gmax, 1);
      for (int j = 0; j < N; j++) begin
        pv[s+j][j] = !(r == skew_row && j == 1);
        pd[s+j][j*DW +: DW] = $urandom;
      end
    end
    plen = s + N;
  endtask

  task automatic play(input int en_pct, input int rdy_pct,
                      input int rdy_delay, input int stall_at,
                      input int max_cyc, input bit wait_done);
    int k, c;
    bit en, rdy;
    k = 0;
    c = 0;
    while (c < max_cyc) begin
      if (k >= plen && (!wait_done || m_done)) break;
      if (stall_at >= 0 && c >= stall_at && c < stall_at + 3)
        en = 0;
      else
        en = $urandom_range(99) < en_pct;
      rdy = c >= rdy_delay && $urandom_range(99) < rdy_pct;
      if (en && k < plen) begin
        cycle(1, 0, rdy, pv[k], pd[k]);
        k++;
      end else begin
        cycle(en, 0, rdy, '0, '0);
      end
      c++;
    end
    if (wait_done) chk("done_end", done, 1);
  endtask

  initial begin
    reset = 1;
    general_enable = 0;
    start = 0;
    out_ready = 0;
    psum_valid = '0;
    psum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_skew", skew_err, 0);
    reset = 0;
    model_reset();

    // Back-to-back rows, consumer always ready.
    do_start();
    build(1, -1);
    play(100, 100, 0, -1, 200, 1);

    // Consumer stalls: head held stable until ready.
    do_start();
    build(1, -1);
    play(100, 100, 10, -1, 200, 1);

    // No consumer for a while: FIFO overflows.
    do_start();
    build(1, -1);
    play(100, 100, 20, -1, 200, 1);
    chk("ovf_sticky", overflow, 1);

    // Column 1 drops valid on row 1.
    do_start();
    build(1, 1);
    play(100, 100, 0, -1, 200, 1);
    chk("skew_sticky", skew_err, 1);

    // Three-cycle enable stall mid-stream.
    do_start();
    build(1, -1);
    play(100, 100, 0, 3, 200, 1);

    // Abort during drain with rows buffered.
    do_start();
    build(1, -1);
    play(100, 0, 0, -1, 100, 0);
    chk("pre_abort_vld", out_valid, 1);
    do_start();
    chk("abort_flush", out_valid, 0);
    chk("abort_done", done, 0);
    build(2, -1);
    play(100, 100, 0, -1, 200, 1);

    // Reset mid-collect clears everything at once.
    do_start();
    build(1, -1);
    play(100, 0, 0, -1, 5, 0);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_skew", skew_err, 0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    do_start();
    build(1, -1);
    play(100, 100, 0, -1, 200, 1);

    // Random gaps, random enable and ready.
    for (int m = 0; m < 25; m++) begin
      do_start();
      build(3, -1);
      play(80, 70, 0, -1, 400, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Receives skewed partial-sum outputs from the bottom edge of the systolic array and realigns them into whole result rows.
- Buffers aligned rows in a small FIFO and streams them out over a valid/ready handshake.
- Raises done once all rows of one matrix product have been delivered.
- Sits downstream of the array, mirroring the scheduler that feeds it; its start is the scheduler's done.

Parameters:
MATRIX_SIZE, 2, array dimension N; number of columns and rows per result matrix
DATA_SIZE, 32, width of one partial sum / result element
FIFO_DEPTH, 4, aligned-row buffer depth; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
general_enable  input  1  global advance enable, same meaning as the rest of the array
start  input  1  one-cycle pulse; arms collection of a new matrix
psum_in  input  MATRIX_SIZE*DATA_SIZE  column j at bits [j*DATA_SIZE +: DATA_SIZE]
psum_valid  input  MATRIX_SIZE  per-column valid; column j lags column 0 by j cycles
out_data  output  MATRIX_SIZE*DATA_SIZE  aligned row, same column packing as psum_in
out_valid  output  1  out_data holds a row
out_ready  input  1  consumer accepts the row when out_valid && out_ready
done  output  1  all MATRIX_SIZE rows delivered; sticky until start or reset
overflow  output  1  sticky: an aligned row arrived while the FIFO was full
skew_err  output  1  sticky: columns disagreed on valid at the alignment point

Behaviour:
- Reset values: out_valid=0, out_data=0, done=0, overflow=0, skew_err=0. FIFO empty, counters 0, FSM in IDLE.
- Deskew: column j passes through MATRIX_SIZE-1-j register stages (data and valid). Column MATRIX_SIZE-1 has zero stages.
- Aligned row valid = delayed valid of column 0. skew_err sets if any delayed column valid differs from it in the same cycle.
- Latency: column 0 presented in cycle c, column j in cycle c+j -> row visible on out_data/out_valid in cycle c+MATRIX_SIZE when the FIFO was empty.
- FIFO:
  - Write on aligned valid in state COLLECT. Pop on out_valid && out_ready.
  - Simultaneous push and pop when full is permitted; the pop frees the slot, so no overflow occurs.
  - Push when full and no pop: row dropped, overflow sets; the row still counts toward rows_in.
  - Pointer width is clog2(FIFO_DEPTH)+1; wrap-around is by natural binary overflow.
  - Show-ahead output: out_data is the head entry, and out_valid = !empty && general_enable.
- general_enable low: deskew stages, FIFO and counters freeze; out_valid is forced low so no transfer can occur.
- FSM:
  - IDLE: accepts start. On start -> COLLECT, clearing rows_in, rows_out, done, overflow and skew_err. Aligned rows arriving in IDLE are ignored.
  - COLLECT: count rows_in on each aligned valid. When rows_in reaches MATRIX_SIZE -> DRAIN. Further aligned valids are ignored and set skew_err.
  - DRAIN: when rows_out == MATRIX_SIZE, or FIFO empty after any overflow -> DONE.
  - DONE: done=1. On start -> COLLECT, same clears as from IDLE.
  - start in COLLECT or DRAIN: abort. Flush the FIFO, clear counters and flags, restart in COLLECT.
- Counters: rows_in and rows_out are clog2(MATRIX_SIZE)+1 bits and saturate at MATRIX_SIZE.
- Reset mid-operation: immediate return to the reset state; partial rows are discarded.

Optional Feature:
RESULT_COLLECTOR_ROW_TAG_EN
- Defined: adds output out_row_idx, clog2(MATRIX_SIZE) bits wide. It carries the index of the head row (0..MATRIX_SIZE-1), stored in the FIFO alongside the data, reset 0.
- Undefined: the port is absent and the FIFO stores data only; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, COLLECT, DRAIN, DONE);
  - a ROW_W = MATRIX_SIZE*DATA_SIZE helper;
  - a clog2-based counter-width function, reused by the scheduler.
- One sub-module, result_row_fifo: synchronous FIFO with show-ahead output and full/empty flags, parameterized by width and depth.
- The deskew delay lines stay inline as a generate loop.

Test Plan:
- N=2, DATA_SIZE=32. start; col0=0x11 at cycle 1, col1=0x22 at cycle 2; col0=0x33 at 2, col1=0x44 at 3; out_ready=1 -> rows {0x22,0x11} at cycle 3 and {0x44,0x33} at cycle 4; done=1 at cycle 5.
- Same stimulus with out_ready=0 until cycle 10 -> out_valid held with the first row stable from cycle 3. Both rows pop at cycles 10–11, then done.
- FIFO_DEPTH=2, out_ready=0 throughout, N=4, four rows pushed -> overflow=1 on the 3rd row, FIFO holds rows 0–1, done stays 0 until the FIFO drains.
- col1 valid missing for one row -> skew_err=1 at the alignment cycle; row still pushed per column 0.
- general_enable low for 3 cycles mid-stream -> out_valid=0 during the stall and no data lost. Rows are delayed by exactly 3 cycles.
- start pulse in DRAIN with one row buffered -> FIFO flushed, out_valid=0 next cycle, done=0, new collection succeeds. Also assert reset mid-COLLECT -> all outputs 0 immediately.
